// File: rtl/aes_key_expand.sv
// Forward AES-128 key schedule: loads a cipher key and emits round keys 1..10, one per clock; optional round-key store under AES_KEY_STORE_EN.
// Latency: start accepted -> done pulse 10 cycles later; one expansion per 11 cycles (restart allowed in the DONE cycle).
// Backpressure: start is taken only while ready=1; start during RUN is ignored.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry i sits at bits [8*(255-i) +: 8]; 255-i is ~i for an 8-bit index.
    assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module aes_key_expand #(
    parameter int         NR        = 10,      // fixed for AES-128
    parameter logic [7:0] RCON_INIT = 8'h01
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [3:0]   round_idx,
    output logic [127:0] rnd_key,
    output logic [127:0] final_key,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] LAST = 4'(NR - 1);

    state_t       state;
    logic [7:0]   rcon;
    logic [31:0]  w0, w1, w2, w3, rot, sub, t;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign {w0, w1, w2, w3} = rnd_key;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[8*i +: 8]),
            .y (sub[8*i +: 8])
        );
    end

    assign t        = sub ^ {rcon, 24'h0};
    assign n0       = w0 ^ t;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // ready is high exactly in IDLE and DONE, so it doubles as the accept qualifier.
    assign accept = ready & start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            round_idx <= '0;
            rnd_key   <= '0;
            final_key <= '0;
            rcon      <= RCON_INIT;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        rnd_key   <= key_in;
                        round_idx <= '0;
                        rcon      <= RCON_INIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rnd_key   <= next_key;
                    round_idx <= round_idx + 4'd1;
                    rcon      <= xtime(rcon);
                    if (round_idx == LAST) begin
                        final_key <= next_key;
                        state     <= DONE;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AES_KEY_STORE_EN
    logic [127:0] store [0:10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 11; k++) store[k] <= '0;
            rd_key <= '0;
        end else begin
            if (accept)
                store[0] <= key_in;
            else if (state == RUN)
                store[round_idx + 4'd1] <= next_key;
            rd_key <= (rd_idx <= 4'd10) ? store[rd_idx] : '0;
        end
    end
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^{rd_idx, accept};
    assign rd_key        = '0;
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 vectors, start-while-busy, mid-run reset, back-to-back restart.
module tb_aes_key_expand;
    logic         clk, rst_n, start;
    logic [127:0] key_in;
    logic         ready, busy, done;
    logic [3:0]   round_idx, rd_idx;
    logic [127:0] rnd_key, final_key, rd_key;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1F = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2F = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } vec_t;
    vec_t tbl [11];

    aes_key_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .round_idx (round_idx),
        .rnd_key   (rnd_key),
        .final_key (final_key),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ticks until done is seen, at most 30; returns the number of ticks taken.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic launch(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
        key_in = '1;
    endtask

    initial begin
        int n, at, cnt;
        tbl[0]  = '{4'd0,  K1};
        tbl[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tbl[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tbl[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tbl[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tbl[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tbl[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        tbl[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tbl[10] = '{4'd10, K1F};

        rst_n = 1'b0; start = 1'b0; key_in = '0; rd_idx = '0;
        repeat (2) tick();
        chk("rst_ready", 128'(ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_round_idx", 128'(round_idx), 128'd0);
        chk("rst_rnd_key", rnd_key, 128'd0);
        chk("rst_final_key", final_key, 128'd0);
        chk("rst_rd_key", rd_key, 128'd0);
        rst_n = 1'b1;
        tick();

        // FIPS-197 run, every round key checked in order.
        launch(K1);
        chk("load_rnd_key", rnd_key, tbl[0].key);
        chk("load_round_idx", 128'(round_idx), 128'(tbl[0].idx));
        chk("load_busy", 128'(busy), 128'd1);
        chk("load_ready", 128'(ready), 128'd0);
        for (int r = 1; r <= 10; r++) begin
            tick();
            chk($sformatf("rnd_key_%0d", r), rnd_key, tbl[r].key);
            chk($sformatf("round_idx_%0d", r), 128'(round_idx), 128'(tbl[r].idx));
            chk($sformatf("done_at_%0d", r), 128'(done), 128'(r == 10));
        end
        chk("fips_final_key", final_key, K1F);
        chk("done_state_ready", 128'(ready), 128'd1);
        tick();
        chk("done_one_cycle", 128'(done), 128'd0);
        chk("idle_round_idx_hold", 128'(round_idx), 128'd10);
        chk("idle_ready", 128'(ready), 128'd1);

`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd1;
        tick();
        chk("store_rd_1", rd_key, tbl[1].key);
        rd_idx = 4'd10;
        tick();
        chk("store_rd_10", rd_key, K1F);
        rd_idx = 4'd12;
        tick();
        chk("store_rd_12", rd_key, 128'd0);
        rd_idx = 4'd0;
`else
        rd_idx = 4'd1;
        tick();
        chk("rd_key_tied", rd_key, 128'd0);
        rd_idx = 4'd0;
`endif

        // Second key, latency measured from the accepting edge.
        launch(K2);
        wait_done(n);
        chk("k2_latency", 128'(n), 128'd10);
        chk("k2_final_key", final_key, K2F);
        tick();

        // start with a new key during round 5 must be ignored.
        launch(K1);
        repeat (4) tick();
        start = 1'b1; key_in = K2;
        tick();
        start = 1'b0; key_in = '0;
        chk("ignore_round_idx", 128'(round_idx), 128'd5);
        cnt = 0; at = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done === 1'b1) begin
                cnt++;
                if (at == 0) at = i;
            end
        end
        chk("ignore_done_count", 128'(cnt), 128'd1);
        chk("ignore_done_at", 128'(at), 128'd5);
        chk("ignore_final_key", final_key, K1F);

        // Asynchronous reset in round 6.
        launch(K1);
        repeat (6) tick();
        chk("pre_rst_round_idx", 128'(round_idx), 128'd6);
        rst_n = 1'b0;
        #1;
        chk("midrst_rnd_key", rnd_key, 128'd0);
        chk("midrst_final_key", final_key, 128'd0);
        chk("midrst_round_idx", 128'(round_idx), 128'd0);
        chk("midrst_ready", 128'(ready), 128'd1);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_done", 128'(done), 128'd0);
        #2 rst_n = 1'b1;
        tick();
        launch(K2);
        wait_done(n);
        chk("post_rst_latency", 128'(n), 128'd10);
        chk("post_rst_final_key", final_key, K2F);
        tick();

        // Back-to-back: restart in the DONE cycle.
        launch(K1);
        wait_done(n);
        chk("b2b_first_latency", 128'(n), 128'd10);
        chk("b2b_first_final", final_key, K1F);
        launch(K2);
        chk("b2b_done_single", 128'(done), 128'd0);
        chk("b2b_busy", 128'(busy), 128'd1);
        wait_done(n);
        chk("b2b_gap", 128'(n + 1), 128'd11);
        chk("b2b_second_final", final_key, K2F);
`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd0;
        tick();
        chk("store_rd_0_after_b2b", rd_key, K2);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end
endmodule
